bsg_two_fifo: RTL and testbench

BSG_TWO_FIFO -- requirements
Module: bsg_two_fifo

---
 rtl/bsg_two_fifo_pkg.sv | 5 +
 rtl/bsg_two_fifo_mem.sv | 27 ++
 rtl/bsg_two_fifo.sv | 78 +++++++
 tb/tb_bsg_two_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bsg_two_fifo_pkg.sv
// bsg_two_fifo_pkg: shared depth constant and pointer type for the two-entry FIFO
package bsg_two_fifo_pkg;
    localparam int depth_lp = 2;
    typedef logic ptr_t;
endpackage

// File: rtl/bsg_two_fifo_mem.sv
// bsg_two_fifo_mem: 2 x width_p storage, synchronous write port, asynchronous read port
module bsg_two_fifo_mem
    import bsg_two_fifo_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               w_v_i,
    input  ptr_t               w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  ptr_t               r_addr_i,
    output logic [width_p-1:0] r_data_o
);
    logic [width_p-1:0] mem_r [depth_lp];

    // clear both slots on reset, otherwise write the addressed slot on request
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < depth_lp; k++) mem_r[k] <= '0;
        end else if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];
endmodule

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry registered FIFO; define BSG_TWO_FIFO_ASSERT_EN for protocol assertions and verbose_p logging
module bsg_two_fifo
    import bsg_two_fifo_pkg::*;
#(
    parameter int width_p                 = 16,
    parameter int verbose_p               = 0,
    parameter int allow_enq_deq_on_full_p = 0,
    parameter int ready_THEN_valid_p      = allow_enq_deq_on_full_p
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_param_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    ptr_t head_r, tail_r;
    logic empty_r, full_r, enq, deq;

    assign ready_param_o = (allow_enq_deq_on_full_p != 0) ? (~full_r | yumi_i) : ~full_r;
    assign enq           = (ready_THEN_valid_p != 0) ? v_i : (v_i & ready_param_o);
    assign deq           = yumi_i;
    assign v_o           = ~empty_r;

    bsg_two_fifo_mem #(.width_p(width_p)) mem (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .w_v_i    (enq),
        .w_addr_i (tail_r),
        .w_data_i (data_i),
        .r_addr_i (head_r),
        .r_data_o (data_o)
    );

    // pointers advance per transfer; flags change only when exactly one side moves
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (enq) tail_r <= ~tail_r;
            if (deq) head_r <= ~head_r;
            if (enq & ~deq) begin
                empty_r <= 1'b0;
                full_r  <= ~empty_r;
            end else if (deq & ~enq) begin
                full_r  <= 1'b0;
                empty_r <= ~full_r;
            end
        end
    end

`ifdef BSG_TWO_FIFO_ASSERT_EN
    // flag dequeue from empty and enqueue into a full FIFO that is not being drained
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && empty_r)) else $error("bsg_two_fifo: yumi_i while empty");
            assert (!(enq && full_r && !(allow_enq_deq_on_full_p != 0 && yumi_i)))
                else $error("bsg_two_fifo: enqueue while full");
        end
    end

    // optional event log of every transfer
    always_ff @(posedge clk_i) begin
        if (!reset_i && verbose_p != 0) begin
            if (enq) $display("%m: enq %h", data_i);
            if (deq) $display("%m: deq %h", data_o);
        end
    end
`else
    if (verbose_p != 0) begin : g_verbose_off
    end
`endif
endmodule

// File: tb/tb_bsg_two_fifo.sv
// tb_bsg_two_fifo: default and enq-on-full instances checked against a count/array FIFO model
module tb_bsg_two_fifo;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i [2];
    logic        yumi_i [2];
    logic        v_o [2];
    logic        ready [2];
    logic [15:0] data_i [2];
    logic [15:0] data_o [2];
    logic [15:0] mq [2][2];
    int          mn [2];
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    bsg_two_fifo #(.width_p(16)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .ready_param_o(ready[0]), .data_i(data_i[0]),
        .v_i(v_i[0]), .v_o(v_o[0]), .data_o(data_o[0]), .yumi_i(yumi_i[0])
    );

    bsg_two_fifo #(.width_p(16), .allow_enq_deq_on_full_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .ready_param_o(ready[1]), .data_i(data_i[1]),
        .v_i(v_i[1]), .v_o(v_o[1]), .data_o(data_o[1]), .yumi_i(yumi_i[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] d, input logic y);
        v_i[i]    = v;
        data_i[i] = d;
        yumi_i[i] = y;
    endtask

    function automatic logic model_ready(input int i);
        return mn[i] < 2 || (i == 1 && yumi_i[i]);
    endfunction

    task automatic tick();
        logic enq [2];
        logic deq [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready%0d", i), {31'b0, ready[i]}, {31'b0, model_ready(i)});
            enq[i] = v_i[i] && model_ready(i);
            deq[i] = yumi_i[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (deq[i]) begin
                mq[i][0] = mq[i][1];
                mn[i]--;
            end
            if (enq[i]) begin
                mq[i][mn[i]] = data_i[i];
                mn[i]++;
            end
            check($sformatf("v_o%0d", i), {31'b0, v_o[i]}, {31'b0, mn[i] > 0});
            if (mn[i] > 0) check($sformatf("data_o%0d", i), {16'b0, data_o[i]}, {16'b0, mq[i][0]});
        end
        @(negedge clk);
    endtask

    initial begin
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 16'h0, 1'b0);
            mn[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_v_o", {31'b0, v_o[i]}, 32'd0);
            check("rst_ready", {31'b0, ready[i]}, 32'd1);
            check("rst_data_o", {16'b0, data_o[i]}, 32'd0);
        end
        reset_i = 1'b0;
        tick();
        check("idle_v_o", {31'b0, v_o[0]}, 32'd0);
        check("idle_ready", {31'b0, ready[0]}, 32'd1);

        drive(0, 1'b1, 16'h1111, 1'b0);
        tick();
        drive(0, 1'b1, 16'h2222, 1'b0);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        #1;
        check("full_v_o", {31'b0, v_o[0]}, 32'd1);
        check("full_data", {16'b0, data_o[0]}, 32'h1111);
        check("full_ready", {31'b0, ready[0]}, 32'd0);

        drive(0, 1'b0, 16'h0, 1'b1);
        tick();
        check("deq1_data", {16'b0, data_o[0]}, 32'h2222);
        check("deq1_ready", {31'b0, ready[0]}, 32'd1);
        tick();
        check("deq2_v_o", {31'b0, v_o[0]}, 32'd0);

        drive(0, 1'b1, 16'hAAAA, 1'b0);
        tick();
        drive(0, 1'b1, 16'hBBBB, 1'b1);
        tick();
        check("sim_v_o", {31'b0, v_o[0]}, 32'd1);
        check("sim_data", {16'b0, data_o[0]}, 32'hBBBB);
        drive(0, 1'b0, 16'h0, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);

        drive(1, 1'b1, 16'h0001, 1'b0);
        tick();
        drive(1, 1'b1, 16'h0002, 1'b0);
        tick();
        drive(1, 1'b1, 16'h0003, 1'b1);
        #1;
        check("eof_ready", {31'b0, ready[1]}, 32'd1);
        tick();
        check("eof_data0", {16'b0, data_o[1]}, 32'h0001 + 32'h1);
        drive(1, 1'b0, 16'h0, 1'b1);
        tick();
        check("eof_data1", {16'b0, data_o[1]}, 32'h0003);
        tick();
        drive(1, 1'b0, 16'h0, 1'b0);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                logic y, v;
                y = mn[i] > 0 && $urandom_range(0, 2) != 0;
                yumi_i[i] = y;
                v = $urandom_range(0, 1) == 1;
                if (i == 1 && !model_ready(i)) v = 1'b0;
                drive(i, v, 16'($urandom), y);
            end
            tick();
        end

        for (int i = 0; i < 2; i++) drive(i, 1'b0, 16'h0, 1'b0);
        while (mn[0] < 2) begin
            drive(0, 1'b1, 16'h7000 + 16'(mn[0]), 1'b0);
            tick();
        end
        drive(0, 1'b0, 16'h0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("arst_v_o", {31'b0, v_o[i]}, 32'd0);
            check("arst_ready", {31'b0, ready[i]}, 32'd1);
            check("arst_data", {16'b0, data_o[i]}, 32'd0);
            mn[i] = 0;
        end
        @(negedge clk);
        reset_i = 1'b0;
        drive(0, 1'b1, 16'h5555, 1'b0);
        tick();
        check("post_rst_v_o", {31'b0, v_o[0]}, 32'd1);
        check("post_rst_data", {16'b0, data_o[0]}, 32'h5555);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
